// File: rtl/auction_seq_ctrl_if.sv
// Bid/result handshake bundle for the sequential sealed-bid auction controller.
// master = bidder/consumer side, slave = controller side.
// Parameters must match the controller instance that uses the slave modport.
interface auction_seq_ctrl_if #(
  parameter int N_PARTIES = 4,
  parameter int W         = 16
);
  localparam int PW = $clog2(N_PARTIES);

  // auction control and status
  logic          start;
  logic          busy;
  logic          dup_err;

  // bid channel (valid/ready)
  logic          bid_valid;
  logic          bid_ready;
  logic [PW-1:0] bid_party;
  logic [W-1:0]  bid_data;

  // result channel (valid/ready)
  logic          res_valid;
  logic          res_ready;
  logic [PW-1:0] res_winner;
  logic [W-1:0]  res_price;
  logic          res_tie;

  modport master (
    output start, bid_valid, bid_party, bid_data, res_ready,
    input  busy, dup_err, bid_ready, res_valid, res_winner, res_price, res_tie
  );

  modport slave (
    input  start, bid_valid, bid_party, bid_data, res_ready,
    output busy, dup_err, bid_ready, res_valid, res_winner, res_price, res_tie
  );
endinterface

// File: rtl/auction_seq_ctrl.sv
// Streaming sealed-bid auction: one bid per party, running max/argmax, result when all have bid.
// Latency: one cycle per accepted bid; result valid the cycle after the last party's bid.
// Backpressure: bids always accepted in COLLECT; result held until res_ready. Optional AUCTION_SECOND_PRICE_EN.
module auction_seq_ctrl #(
  parameter int N_PARTIES = 4,
  parameter int W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  auction_seq_ctrl_if.slave  bus
);

  localparam int PW = $clog2(N_PARTIES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESULT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [N_PARTIES-1:0] r_seen;       // one bit per party that has bid this auction
  logic [W-1:0]         r_max;        // running maximum
  logic [PW-1:0]        r_winner;     // lowest-index party holding r_max
  logic                 r_tie;        // another party matched r_max
  logic                 r_dup_err;    // sticky until next start
  logic                 r_bid_ready;
  logic                 r_res_valid;
  logic                 r_busy;
  logic [PW-1:0]        r_res_winner;
  logic [W-1:0]         r_res_price;
  logic                 r_res_tie;
`ifdef AUCTION_SECOND_PRICE_EN
  logic [W-1:0]         r_second;     // second-highest bid across distinct parties
`endif

  // ---------------------------------------------------------------------------
  // Next-value datapath for the bid being offered this cycle
  // ---------------------------------------------------------------------------
  logic                 w_accept;
  logic [N_PARTIES-1:0] w_party_bit;
  logic [N_PARTIES-1:0] w_seen_nxt;
  logic                 w_dup;
  logic                 w_first;
  logic                 w_last;
  logic                 w_gt;
  logic                 w_eq;
  logic [W-1:0]         w_max_nxt;
  logic [PW-1:0]        w_winner_nxt;
  logic                 w_tie_nxt;
  logic [W-1:0]         w_price_nxt;
`ifdef AUCTION_SECOND_PRICE_EN
  logic [W-1:0]         w_second_nxt;
`endif

  // Decode the bidder into the seen mask and classify the bid (duplicate / first / last).
  always_comb begin
    w_party_bit                = '0;
    w_party_bit[bus.bid_party] = 1'b1;
    w_accept   = bus.bid_valid && r_bid_ready;
    w_dup      = |(r_seen & w_party_bit);
    w_seen_nxt = r_seen | w_party_bit;
    w_first    = (r_seen == '0);
    w_last     = &w_seen_nxt;
  end

  // Single shared compare of the incoming bid against the running maximum.
  always_comb begin
    w_gt         = (bus.bid_data > r_max);
    w_eq         = (bus.bid_data == r_max);
    w_max_nxt    = r_max;
    w_winner_nxt = r_winner;
    w_tie_nxt    = r_tie;
    if (w_first || w_gt) begin
      // New leader: any earlier tie at the old maximum no longer matters.
      w_max_nxt    = bus.bid_data;
      w_winner_nxt = bus.bid_party;
      w_tie_nxt    = 1'b0;
    end else if (w_eq) begin
      // Equal bids resolve to the lowest party index regardless of arrival order.
      w_tie_nxt = 1'b1;
      if (bus.bid_party < r_winner) begin
        w_winner_nxt = bus.bid_party;
      end
    end
  end

`ifdef AUCTION_SECOND_PRICE_EN
  // Second-highest tracking: a displaced max or a matching max becomes the runner-up.
  always_comb begin
    w_second_nxt = r_second;
    if (w_first) begin
      w_second_nxt = r_second;
    end else if (w_gt) begin
      w_second_nxt = r_max;
    end else if (w_eq) begin
      w_second_nxt = bus.bid_data;
    end else if (bus.bid_data > r_second) begin
      w_second_nxt = bus.bid_data;
    end
  end

  // Vickrey pricing: the winner pays the runner-up bid.
  always_comb begin
    w_price_nxt = w_second_nxt;
  end
`else
  // First-price pricing: the winner pays its own bid.
  always_comb begin
    w_price_nxt = w_max_nxt;
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs
  // ---------------------------------------------------------------------------
  // Sequence IDLE -> COLLECT -> RESULT -> IDLE and update the running state per accepted bid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_seen       <= '0;
      r_max        <= '0;
      r_winner     <= '0;
      r_tie        <= 1'b0;
      r_dup_err    <= 1'b0;
      r_bid_ready  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_res_winner <= '0;
      r_res_price  <= '0;
      r_res_tie    <= 1'b0;
`ifdef AUCTION_SECOND_PRICE_EN
      r_second     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Result registers keep the previous auction's outcome while idle.
          if (bus.start) begin
            r_state     <= S_COLLECT;
            r_seen      <= '0;
            r_max       <= '0;
            r_winner    <= '0;
            r_tie       <= 1'b0;
            r_dup_err   <= 1'b0;
            r_bid_ready <= 1'b1;
            r_busy      <= 1'b1;
`ifdef AUCTION_SECOND_PRICE_EN
            r_second    <= '0;
`endif
          end
        end

        S_COLLECT: begin
          if (w_accept) begin
            if (w_dup) begin
              // A repeat bid from a party is discarded; only the flag records it.
              r_dup_err <= 1'b1;
            end else begin
              r_seen   <= w_seen_nxt;
              r_max    <= w_max_nxt;
              r_winner <= w_winner_nxt;
              r_tie    <= w_tie_nxt;
`ifdef AUCTION_SECOND_PRICE_EN
              r_second <= w_second_nxt;
`endif
              if (w_last) begin
                // Last missing party: publish directly from the next-values so the
                // result is valid one cycle after the final bid.
                r_state      <= S_RESULT;
                r_bid_ready  <= 1'b0;
                r_res_valid  <= 1'b1;
                r_res_winner <= w_winner_nxt;
                r_res_price  <= w_price_nxt;
                r_res_tie    <= w_tie_nxt;
              end
            end
          end
        end

        S_RESULT: begin
          // start is not looked at here, so a start coincident with the handshake is dropped.
          if (bus.res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_bid_ready <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.bid_ready  = r_bid_ready;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_winner = r_res_winner;
  assign bus.res_price  = r_res_price;
  assign bus.res_tie    = r_res_tie;
  assign bus.dup_err    = r_dup_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_auction_seq_ctrl.sv
// Scoreboard bench for auction_seq_ctrl: expected outcome pushed when an auction's bids are
// driven, popped and compared when the result handshake appears.
// Honours AUCTION_SECOND_PRICE_EN the same way the design does.
module tb_auction_seq_ctrl;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int PW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  auction_seq_ctrl_if #(.N_PARTIES(N), .W(W)) bus ();

  auction_seq_ctrl #(.N_PARTIES(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [PW-1:0] winner;
    logic [W-1:0]  price;
    logic          tie;
    logic          dup;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Current auction's bid list, in arrival order.
  int bp[8];
  int bv[8];
  int nb;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference outcome from the whole bid set: highest value wins, lowest index on ties,
  // runner-up is the largest value left after removing one copy of the maximum.
  function automatic exp_t model();
    exp_t e;
    int   val[N];
    bit   seen[N];
    int   mx;
    int   sec;
    int   cnt;
    e.dup = 1'b0;
    for (int p = 0; p < N; p++) begin
      seen[p] = 1'b0;
      val[p]  = 0;
    end
    for (int i = 0; i < nb; i++) begin
      if (seen[bp[i]]) e.dup = 1'b1;
      else begin
        seen[bp[i]] = 1'b1;
        val[bp[i]]  = bv[i];
      end
    end
    mx = -1;
    for (int p = 0; p < N; p++) if (val[p] > mx) mx = val[p];
    cnt = 0;
    e.winner = '0;
    for (int p = N - 1; p >= 0; p--) begin
      if (val[p] == mx) begin
        cnt++;
        e.winner = PW'(p);
      end
    end
    sec = 0;
    if (cnt > 1) sec = mx;
    else for (int p = 0; p < N; p++) if (val[p] != mx && val[p] > sec) sec = val[p];
    e.tie = (cnt > 1);
`ifdef AUCTION_SECOND_PRICE_EN
    e.price = W'(sec);
`else
    e.price = W'(mx);
`endif
    return e;
  endfunction

  task automatic set_bids(input int p0, v0, p1, v1, p2, v2, p3, v3);
    bp[0] = p0; bv[0] = v0; bp[1] = p1; bv[1] = v1;
    bp[2] = p2; bv[2] = v2; bp[3] = p3; bv[3] = v3;
    nb = 4;
  endtask

  task automatic pulse_start(input string tag);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_rdy"}, 32'(bus.bid_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  // Drive the bid list back-to-back; optionally record the expected result.
  task automatic drive_bids(input bit push);
    if (push) sb.push_back(model());
    for (int i = 0; i < nb; i++) begin
      bus.bid_valid = 1'b1;
      bus.bid_party = PW'(bp[i]);
      bus.bid_data  = W'(bv[i]);
      @(posedge clk); #1;
    end
    bus.bid_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, then complete the handshake.
  task automatic collect(input string tag, input bit start_too, output int waited);
    exp_t e;
    waited = 0;
    while (!bus.res_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.res_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_winner"}, 32'(bus.res_winner), 32'(e.winner));
    check({tag, "_price"},  32'(bus.res_price),  32'(e.price));
    check({tag, "_tie"},    32'(bus.res_tie),    32'(e.tie));
    check({tag, "_dup"},    32'(bus.dup_err),    32'(e.dup));
    check({tag, "_rdy_lo"}, 32'(bus.bid_ready),  32'd0);
    bus.res_ready = 1'b1;
    bus.start     = start_too;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_done"}, {30'd0, bus.res_valid, bus.busy}, 32'd0);
    check({tag, "_hold"}, {15'd0, bus.dup_err, bus.res_price}, {15'd0, e.dup, e.price});
    if (start_too) check({tag, "_start_ignored"}, 32'(bus.bid_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int   w;
    exp_t e;
    bus.start     = 1'b0;
    bus.bid_valid = 1'b0;
    bus.bid_party = '0;
    bus.bid_data  = '0;
    bus.res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {bus.bid_ready, bus.res_valid, bus.busy, bus.dup_err, bus.res_tie,
                         bus.res_winner, bus.res_price}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy", 32'(bus.bid_ready), 32'd0);

    // Ascending, back-to-back: also measures start-to-result latency.
    pulse_start("asc");
    set_bids(0, 10, 1, 20, 2, 30, 3, 40);
    drive_bids(1'b1);
    collect("asc", 1'b0, w);
    check("asc_latency", 32'(1 + nb + w), 32'(N + 1));

    // Out-of-order with full-width values; start coincides with the result handshake.
    pulse_start("ooo");
    set_bids(2, 16'hFFFF, 0, 5, 3, 7, 1, 16'hFFFE);
    drive_bids(1'b1);
    collect("ooo", 1'b1, w);

    // Tie at the maximum resolved to the lower party.
    pulse_start("tie");
    set_bids(3, 100, 1, 100, 0, 50, 2, 1);
    drive_bids(1'b1);
    collect("tie", 1'b0, w);

    // Duplicate bid from party 0 is dropped.
    pulse_start("dup");
    bp[0] = 0; bv[0] = 9;  bp[1] = 0; bv[1] = 200; bp[2] = 1; bv[2] = 1;
    bp[3] = 2; bv[3] = 2;  bp[4] = 3; bv[4] = 3;   nb = 5;
    drive_bids(1'b1);
    collect("dup", 1'b0, w);

    // Backpressure: result held for 10 cycles, start pulse inside the window ignored.
    pulse_start("bp");
    set_bids(1, 7, 0, 3, 3, 7, 2, 9);
    drive_bids(1'b1);
    check("bp_valid", 32'(bus.res_valid), 32'd1);
    e = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      bus.start = (c == 4);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("bp_stable", {13'd0, bus.res_valid, bus.res_tie, bus.res_winner, bus.res_price},
            {13'd0, 1'b1, e.tie, e.winner, e.price});
    end
    check("bp_no_rdy", 32'(bus.bid_ready), 32'd0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("bp_idle", {29'd0, bus.res_valid, bus.busy, bus.bid_ready}, 32'd0);

    // Reset after two accepted bids clears everything; a fresh auction works afterwards.
    pulse_start("rst");
    bp[0] = 2; bv[0] = 500; bp[1] = 1; bv[1] = 600; nb = 2;
    drive_bids(1'b0);
    check("rst_midway_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outs", {bus.bid_ready, bus.res_valid, bus.busy, bus.dup_err, bus.res_tie,
                             bus.res_winner, bus.res_price}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_result", 32'(bus.res_valid), 32'd0);
    pulse_start("post");
    set_bids(0, 1, 1, 2, 2, 3, 3, 4);
    drive_bids(1'b1);
    collect("post", 1'b0, w);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/auction_seq_ctrl.md
# auction_seq_ctrl

Sequential controller for the sealed-bid auction datapath: it collects one bid per party over a valid/ready handshake in any arrival order and keeps a running maximum. Once every party has bid, it presents the winning party index and price. It sits in front of the result consumer and replaces the fully combinational four-party max/argmax network with an area-lean streaming equivalent, one comparator reused per bid.

## Interface
- N_PARTIES, 4: number of bidders; power of two, 2..16.
- W, 16: bid width in bits, unsigned.
- PW, $clog2(N_PARTIES): party-index width (derived; do not override).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; opens a new auction (honoured only in IDLE).
- bid_valid  in  1  bid offered.
- bid_ready  out  1  controller can accept a bid.
- bid_party  in  PW  index of the bidding party.
- bid_data  in  W  bid value.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_winner  out  PW  winning party index.
- res_price  out  W  clearing price.
- res_tie  out  1  another party bid exactly the maximum.
- dup_err  out  1  sticky per auction; a party bid twice.
- busy  out  1  high in COLLECT or RESULT.

## Operation
- States: IDLE, COLLECT, RESULT.
- IDLE -> COLLECT on start. On entry, clear max, second, winner, tie, seen mask and dup_err.
- COLLECT:
  - bid_ready = 1.
  - A bid is accepted when bid_valid && bid_ready.
  - If seen[bid_party] is already set, drop the bid and set dup_err.
  - Otherwise set seen[bid_party] and compare bid_data with max:
    - first bid, or bid_data > max: load max, set winner = bid_party, clear tie.
    - bid_data == max: set tie; winner becomes the lower of winner and bid_party.
    - bid_data < max: no change to max or winner.
  - All comparisons are unsigned, full W bits, no truncation. A bid of 0 is legal.
- COLLECT -> RESULT on the cycle the last unseen party is accepted (seen mask becomes all-ones).
- RESULT:
  - res_valid = 1; outputs are held stable.
  - res_price = max; res_winner = winner; res_tie = tie.
  - RESULT -> IDLE when res_ready is high.
- start outside IDLE is ignored. start in the same cycle as the RESULT handshake is also ignored, because the state is not yet IDLE.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - State goes to IDLE.
  - bid_ready, res_valid, busy, dup_err, res_tie = 0.
  - res_winner = 0, res_price = 0.
- start -> bid_ready high on the next cycle.
- The compare/update completes in the accepting cycle, so back-to-back bids are accepted every cycle.
- Last accepted bid -> res_valid high on the next cycle. Minimum auction length is N_PARTIES + 1 cycles after start.
- bid_ready is 0 for the whole RESULT state.
- res_valid drops in the cycle after the res_ready handshake.
- Result outputs are registered and hold their last values in IDLE. dup_err holds until the next start.
- Reset mid-auction discards all partial state; no result is produced.

## Configuration
- AUCTION_SECOND_PRICE_EN:
  - Defined: the block also tracks the second-highest distinct-party bid.
    - When max is displaced, second takes the old max.
    - When bid_data == max or second < bid_data < max, second = bid_data.
    - res_price = second (Vickrey price). With a tie, second equals max.
  - Undefined: no second register is built, and res_price = max (first price).

## Test plan
- Ascending bids p0=10, p1=20, p2=30, p3=40, back-to-back -> res_valid on cycle 5 after start; winner=3, price=40, tie=0 (second-price build: price=30).
- Out-of-order bids p2=0xFFFF, p0=5, p3=7, p1=0xFFFE -> winner=2, price=0xFFFF (second-price: 0xFFFE).
- Tie: p3=100, p1=100, p0=50, p2=1 -> winner=1, tie=1, price=100 (second-price: 100).
- Duplicate: p0=9, p0=200, p1=1, p2=2, p3=3 -> second p0 bid dropped, dup_err=1, winner=0, price=9.
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid and outputs stable; a start pulse during this window is ignored. Raise res_ready -> next cycle IDLE, busy=0.
- Reset after two accepted bids -> immediately all outputs 0; a fresh start plus four bids of 1,2,3,4 (p0..p3) -> winner=3.
